// File: rtl/snake_kb_pkg.sv
// Shared constants for the keyboard direction arbiter: direction encoding,
// set-2 scan codes, prefix-parser states and the reversal test.
package snake_kb_pkg;

   localparam logic [4:0] DIR_UP    = 5'b00010;
   localparam logic [4:0] DIR_LEFT  = 5'b00100;
   localparam logic [4:0] DIR_DOWN  = 5'b01000;
   localparam logic [4:0] DIR_RIGHT = 5'b10000;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_RIGHT = 8'h74;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK
   } kb_state_t;

   function automatic logic is_reverse(input logic [4:0] a, input logic [4:0] b);
      return (a == DIR_UP    && b == DIR_DOWN)  ||
             (a == DIR_DOWN  && b == DIR_UP)    ||
             (a == DIR_LEFT  && b == DIR_RIGHT) ||
             (a == DIR_RIGHT && b == DIR_LEFT);
   endfunction

endpackage

// File: rtl/dir_queue.sv
// Small per-player direction FIFO (DEPTH 1..4). Entry 0 is the head; a pop
// shifts the array down, and a same-cycle push lands after the shifted entries.
module dir_queue #(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       push,
   input  logic       pop,
   input  logic [4:0] din,
   output logic [4:0] head,
   output logic [4:0] tail,
   output logic       full,
   output logic       empty
);

   logic [4:0] mem [4];
   logic [2:0] cnt;
   logic [1:0] widx;

   // Callers only pop when non-empty and only push to a full queue while popping.
   always_comb widx = pop ? 2'(cnt - 3'd1) : cnt[1:0];

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         cnt <= 3'd0;
      end else begin
         cnt <= cnt + 3'(push) - 3'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (pop) begin
         for (int i = 0; i < 3; i++) mem[i] <= mem[i+1];
      end
      if (push) mem[widx] <= din;
   end

   assign head  = mem[0];
   assign tail  = mem[2'(cnt - 3'd1)];
   assign full  = (cnt == 3'(DEPTH));
   assign empty = (cnt == 3'd0);

endmodule

// File: rtl/kb_dir_arbiter.sv
// PS/2 scan-byte parser and two-player direction arbiter: decodes make codes into
// per-player requests, queues them and commits one per player on each game tick.
module kb_dir_arbiter
   import snake_kb_pkg::*;
#(
   parameter int QDEPTH  = 2,
   parameter int TMO_CYC = 2_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   input  logic       frame_err,
   input  logic       tick,
   output logic [4:0] dir_p1,
   output logic [4:0] dir_p2,
   output logic       game_rst,
   output logic       q_ovf
);

   localparam int CW = $clog2(TMO_CYC + 1);

   // All inputs are single-cycle strobes with no back-pressure: byte_valid,
   // frame_err and tick are each acted on in exactly the cycle they are high.
   kb_state_t     state, state_nxt;
   logic [CW-1:0] tmo_cnt, tmo_cnt_nxt;
   logic          mk_v, mk_ext;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         tmo_cnt <= '0;
      end else begin
         state   <= state_nxt;
         tmo_cnt <= tmo_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      tmo_cnt_nxt = tmo_cnt;
      mk_v        = 1'b0;
      mk_ext      = 1'b0;
      if (frame_err || game_rst) begin
         state_nxt   = ST_IDLE;
         tmo_cnt_nxt = '0;
      end else if (byte_valid) begin
         tmo_cnt_nxt = '0;
         state_nxt   = ST_IDLE;
         case (state)
            ST_IDLE: begin
               if (byte_data == SC_EXT)      state_nxt = ST_EXT;
               else if (byte_data == SC_BRK) state_nxt = ST_BRK;
               else                          mk_v      = 1'b1;
            end
            ST_EXT: begin
               if (byte_data == SC_BRK) begin
                  state_nxt = ST_EXT_BRK;
               end else begin
                  mk_v   = 1'b1;
                  mk_ext = 1'b1;
               end
            end
            default: ;
         endcase
      end else if (state != ST_IDLE) begin
         if (tmo_cnt == CW'(TMO_CYC - 1)) begin
            state_nxt   = ST_IDLE;
            tmo_cnt_nxt = '0;
         end else begin
            tmo_cnt_nxt = tmo_cnt + CW'(1);
         end
      end else begin
         tmo_cnt_nxt = '0;
      end
   end

   logic       d1_v, d2_v, d_rst;
   logic [4:0] d1_dir, d2_dir;

   always_comb begin
      d1_v   = 1'b0;
      d2_v   = 1'b0;
      d_rst  = 1'b0;
      d1_dir = DIR_UP;
      d2_dir = DIR_UP;
      if (mk_v && !mk_ext) begin
         case (byte_data)
            SC_W:     begin d1_v = 1'b1; d1_dir = DIR_UP;    end
            SC_A:     begin d1_v = 1'b1; d1_dir = DIR_LEFT;  end
            SC_S:     begin d1_v = 1'b1; d1_dir = DIR_DOWN;  end
            SC_D:     begin d1_v = 1'b1; d1_dir = DIR_RIGHT; end
            SC_ENTER: d_rst = 1'b1;
            default: ;
         endcase
      end else if (mk_v) begin
         case (byte_data)
            SC_UP:    begin d2_v = 1'b1; d2_dir = DIR_UP;    end
            SC_LEFT:  begin d2_v = 1'b1; d2_dir = DIR_LEFT;  end
            SC_DOWN:  begin d2_v = 1'b1; d2_dir = DIR_DOWN;  end
            SC_RIGHT: begin d2_v = 1'b1; d2_dir = DIR_RIGHT; end
            default: ;
         endcase
      end
   end

   logic       req1_v, req2_v;
   logic [4:0] req1_dir, req2_dir;
   logic [4:0] q1_head, q1_tail, q2_head, q2_tail;
   logic       q1_full, q1_empty, q2_full, q2_empty;
   logic       pop1, pop2, new1, new2, push1, push2, drop1, drop2;

   // Duplicate suppression compares against what the player will end up heading toward.
   always_comb begin
      pop1  = tick && !game_rst && !q1_empty;
      pop2  = tick && !game_rst && !q2_empty;
      new1  = req1_v && !game_rst && (req1_dir != (q1_empty ? dir_p1 : q1_tail));
      new2  = req2_v && !game_rst && (req2_dir != (q2_empty ? dir_p2 : q2_tail));
      push1 = new1 && (!q1_full || pop1);
      push2 = new2 && (!q2_full || pop2);
      drop1 = new1 && q1_full && !pop1;
      drop2 = new2 && q2_full && !pop2;
   end

   dir_queue #(.DEPTH(QDEPTH)) u_q1 (
      .clk(clk), .rst_n(rst_n), .flush(game_rst), .push(push1), .pop(pop1),
      .din(req1_dir), .head(q1_head), .tail(q1_tail), .full(q1_full), .empty(q1_empty)
   );

   dir_queue #(.DEPTH(QDEPTH)) u_q2 (
      .clk(clk), .rst_n(rst_n), .flush(game_rst), .push(push2), .pop(pop2),
      .din(req2_dir), .head(q2_head), .tail(q2_tail), .full(q2_full), .empty(q2_empty)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         req1_v   <= 1'b0;
         req2_v   <= 1'b0;
         req1_dir <= DIR_UP;
         req2_dir <= DIR_UP;
         game_rst <= 1'b0;
         dir_p1   <= DIR_RIGHT;
         dir_p2   <= DIR_LEFT;
         q_ovf    <= 1'b0;
      end else begin
         req1_v   <= d1_v;
         req2_v   <= d2_v;
         req1_dir <= d1_dir;
         req2_dir <= d2_dir;
         game_rst <= d_rst;
         if (game_rst) begin
            dir_p1 <= DIR_RIGHT;
            dir_p2 <= DIR_LEFT;
            q_ovf  <= 1'b0;
         end else begin
            if (pop1 && !is_reverse(q1_head, dir_p1)) dir_p1 <= q1_head;
            if (pop2 && !is_reverse(q2_head, dir_p2)) dir_p2 <= q2_head;
            if (drop1 || drop2) q_ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_kb_dir_arbiter.sv
// Self-checking bench for kb_dir_arbiter: directed vector table, timeout and
// abort sequences, then random traffic scored against a queue-based model.
module tb_kb_dir_arbiter;

   localparam int QD  = 2;
   localparam int TMO = 20;

   localparam logic [4:0] U = 5'b00010;
   localparam logic [4:0] L = 5'b00100;
   localparam logic [4:0] D = 5'b01000;
   localparam logic [4:0] R = 5'b10000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_data = 8'h00;
   logic       frame_err = 1'b0;
   logic       tick = 1'b0;
   logic [4:0] dir_p1, dir_p2;
   logic       game_rst, q_ovf;

   kb_dir_arbiter #(.QDEPTH(QD), .TMO_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
      .frame_err(frame_err), .tick(tick), .dir_p1(dir_p1), .dir_p2(dir_p2),
      .game_rst(game_rst), .q_ovf(q_ovf)
   );

   // clock / reset
   always #5 clk = ~clk;

   // scoreboard
   logic [11:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @%0t: got dir1=%b dir2=%b grst=%b ovf=%b, expected dir1=%b dir2=%b grst=%b ovf=%b",
                    name, $time, act[11:7], act[6:2], act[1], act[0], exp[11:7], exp[6:2], exp[1], exp[0]);
   endtask

   function automatic logic [11:0] dut_out();
      return {dir_p1, dir_p2, game_rst, q_ovf};
   endfunction

   // reference model
   logic [4:0] m_dir [2];
   logic [4:0] mq [2][4];
   int         mcnt [2];
   bit         m_ovf, m_grst, m_e0, m_f0;
   int         m_age;
   bit         pend_v;
   int         pend_p;
   logic [4:0] pend_dir;

   function automatic int didx(input logic [4:0] d);
      case (d)
         U: return 0;
         L: return 1;
         D: return 2;
         default: return 3;
      endcase
   endfunction

   function automatic bit opposite(input logic [4:0] a, input logic [4:0] b);
      return ((didx(a) + 2) % 4) == didx(b);
   endfunction

   task automatic model_reset();
      m_dir[0] = R; m_dir[1] = L;
      mcnt[0] = 0;  mcnt[1] = 0;
      m_ovf = 0; m_grst = 0; m_e0 = 0; m_f0 = 0; m_age = 0;
      pend_v = 0; pend_p = 0; pend_dir = U;
   endtask

   task automatic model_step(input bit bv, input logic [7:0] bd, input bit fe, input bit tk);
      bit cur_grst, nv, nrst, e0, f0, pop, want;
      int np;
      logic [4:0] nd, refd, h;
      cur_grst = m_grst;
      nv = 0; nrst = 0; np = 0; nd = U;
      m_age++;
      if (fe || cur_grst) begin
         m_e0 = 0; m_f0 = 0;
      end else if (bv) begin
         e0 = (m_e0 || m_f0) && (m_age <= TMO) && m_e0;
         f0 = (m_e0 || m_f0) && (m_age <= TMO) && m_f0;
         m_age = 0; m_e0 = 0; m_f0 = 0;
         if (f0) begin
         end else if (bd == 8'hF0) begin
            m_f0 = 1; m_e0 = e0;
         end else if (bd == 8'hE0 && !e0) begin
            m_e0 = 1;
         end else if (!e0) begin
            case (bd)
               8'h1D: begin nv = 1; np = 0; nd = U; end
               8'h1C: begin nv = 1; np = 0; nd = L; end
               8'h1B: begin nv = 1; np = 0; nd = D; end
               8'h23: begin nv = 1; np = 0; nd = R; end
               8'h5A: nrst = 1;
               default: ;
            endcase
         end else begin
            case (bd)
               8'h75: begin nv = 1; np = 1; nd = U; end
               8'h6B: begin nv = 1; np = 1; nd = L; end
               8'h72: begin nv = 1; np = 1; nd = D; end
               8'h74: begin nv = 1; np = 1; nd = R; end
               default: ;
            endcase
         end
      end
      if (cur_grst) begin
         m_dir[0] = R; m_dir[1] = L; mcnt[0] = 0; mcnt[1] = 0; m_ovf = 0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            pop  = tk && (mcnt[p] > 0);
            want = pend_v && (pend_p == p);
            if (want) begin
               refd = (mcnt[p] > 0) ? mq[p][mcnt[p]-1] : m_dir[p];
               if (pend_dir == refd) want = 0;
               else if (mcnt[p] == QD && !pop) begin
                  want = 0; m_ovf = 1;
               end
            end
            if (pop) begin
               h = mq[p][0];
               for (int i = 0; i < 3; i++) mq[p][i] = mq[p][i+1];
               mcnt[p]--;
               if (!opposite(h, m_dir[p])) m_dir[p] = h;
            end
            if (want) begin
               mq[p][mcnt[p]] = pend_dir;
               mcnt[p]++;
            end
         end
      end
      pend_v = nv; pend_p = np; pend_dir = nd; m_grst = nrst;
   endtask

   // drivers
   task automatic do_cycle(input bit bv, input logic [7:0] bd, input bit fe, input bit tk,
                           output logic [11:0] act);
      byte_valid = bv; byte_data = bd; frame_err = fe; tick = tk;
      model_step(bv, bd, fe, tk);
      exp_q.push_back({m_dir[0], m_dir[1], m_grst, m_ovf});
      @(posedge clk); #1;
      act = dut_out();
      check("model", act, exp_q.pop_front());
      byte_valid = 0; frame_err = 0; tick = 0;
   endtask

   task automatic send(input logic [7:0] b);
      logic [11:0] a;
      do_cycle(1'b1, b, 1'b0, 1'b0, a);
   endtask

   task automatic idle(input int n);
      logic [11:0] a;
      for (int i = 0; i < n; i++) do_cycle(1'b0, 8'h00, 1'b0, 1'b0, a);
   endtask

   task automatic do_reset();
      rst_n = 0; byte_valid = 0; frame_err = 0; tick = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset", dut_out(), {R, L, 1'b0, 1'b0});
      model_reset();
      rst_n = 1;
   endtask

   // directed vector table
   typedef struct {
      bit         bv;
      logic [7:0] bd;
      bit         tk;
      logic [4:0] e1;
      logic [4:0] e2;
      bit         eg;
      bit         eo;
   } vec_t;

   vec_t vt[$];

   task automatic add_vec(input bit bv, input logic [7:0] bd, input bit tk,
                          input logic [4:0] e1, input logic [4:0] e2, input bit eg, input bit eo);
      vec_t v;
      v.bv = bv; v.bd = bd; v.tk = tk; v.e1 = e1; v.e2 = e2; v.eg = eg; v.eo = eo;
      vt.push_back(v);
   endtask

   logic [7:0] codes [11] = '{8'hE0, 8'hF0, 8'h1D, 8'h1C, 8'h1B, 8'h23,
                              8'h75, 8'h6B, 8'h72, 8'h74, 8'h33};

   initial begin
      logic [11:0] act;
      model_reset();

      add_vec(0, 8'h00, 1, R, L, 0, 0);
      add_vec(1, 8'h1D, 0, R, L, 0, 0);
      add_vec(0, 8'h00, 0, R, L, 0, 0);
      add_vec(0, 8'h00, 1, U, L, 0, 0);
      add_vec(1, 8'hE0, 0, U, L, 0, 0);
      add_vec(1, 8'h75, 0, U, L, 0, 0);
      add_vec(0, 8'h00, 0, U, L, 0, 0);
      add_vec(0, 8'h00, 1, U, U, 0, 0);
      add_vec(1, 8'hE0, 0, U, U, 0, 0);
      add_vec(1, 8'hF0, 0, U, U, 0, 0);
      add_vec(1, 8'h75, 0, U, U, 0, 0);
      add_vec(0, 8'h00, 0, U, U, 0, 0);
      add_vec(0, 8'h00, 1, U, U, 0, 0);
      add_vec(1, 8'h1B, 0, U, U, 0, 0);
      add_vec(0, 8'h00, 0, U, U, 0, 0);
      add_vec(0, 8'h00, 1, U, U, 0, 0);
      add_vec(1, 8'h1C, 0, U, U, 0, 0);
      add_vec(1, 8'h23, 0, U, U, 0, 0);
      add_vec(0, 8'h00, 0, U, U, 0, 0);
      add_vec(0, 8'h00, 1, L, U, 0, 0);
      add_vec(0, 8'h00, 1, L, U, 0, 0);
      add_vec(1, 8'h1D, 0, L, U, 0, 0);
      add_vec(1, 8'h1B, 0, L, U, 0, 0);
      add_vec(1, 8'h23, 0, L, U, 0, 0);
      add_vec(0, 8'h00, 0, L, U, 0, 1);
      add_vec(1, 8'h1C, 0, L, U, 0, 1);
      add_vec(0, 8'h00, 1, U, U, 0, 1);
      add_vec(0, 8'h00, 1, U, U, 0, 1);
      add_vec(0, 8'h00, 1, L, U, 0, 1);
      add_vec(1, 8'h1B, 0, L, U, 0, 1);
      add_vec(1, 8'h5A, 0, L, U, 1, 1);
      add_vec(0, 8'h00, 1, R, L, 0, 0);
      add_vec(0, 8'h00, 1, R, L, 0, 0);

      do_reset();
      foreach (vt[i]) begin
         do_cycle(vt[i].bv, vt[i].bd, 1'b0, vt[i].tk, act);
         check($sformatf("vec%0d", i), act, {vt[i].e1, vt[i].e2, vt[i].eg, vt[i].eo});
      end

      // prefix still live on the last cycle of the window
      send(8'hE0);
      idle(TMO - 1);
      send(8'h75);
      idle(1);
      do_cycle(1'b0, 8'h00, 1'b0, 1'b1, act);
      check("tmo_edge", act, {R, U, 1'b0, 1'b0});

      // prefix expired: 1D is a plain make
      send(8'hE0);
      idle(TMO);
      send(8'h1D);
      idle(1);
      do_cycle(1'b0, 8'h00, 1'b0, 1'b1, act);
      check("tmo_expired", act, {U, U, 1'b0, 1'b0});

      // frame error drops prefix and the byte in the same cycle
      send(8'hE0);
      do_cycle(1'b1, 8'h74, 1'b1, 1'b0, act);
      send(8'h74);
      idle(1);
      do_cycle(1'b0, 8'h00, 1'b0, 1'b1, act);
      check("frame_err", act, {U, U, 1'b0, 1'b0});

      // reset in the middle of a prefix sequence
      send(8'hE0);
      do_reset();
      send(8'h74);
      idle(1);
      do_cycle(1'b0, 8'h00, 1'b0, 1'b1, act);
      check("rst_mid_seq", act, {R, L, 1'b0, 1'b0});

      // random traffic
      for (int n = 0; n < 4000; n++) begin
         bit         bv, fe, tk;
         logic [7:0] bd;
         bv = ($urandom_range(0, 99) < 35);
         fe = ($urandom_range(0, 99) < 2);
         tk = ($urandom_range(0, 99) < 15);
         bd = codes[$urandom_range(0, 10)];
         if ($urandom_range(0, 99) < 3) bd = 8'h5A;
         do_cycle(bv, bd, fe, tk, act);
         if ($urandom_range(0, 199) == 0) idle(TMO + $urandom_range(0, 3) - 2);
         if ($urandom_range(0, 499) == 0) do_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
